// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
// Shared definitions for the instruction-fetch controller: the controller
// state encoding and the default values of its parameters.
package fetch_ctrl_pkg;

  localparam int XLEN        = 32;
  localparam int BOOT_CYCLES = 2;
  localparam int TIMEOUT     = 16;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_WAIT_MEM,
    ST_DRAIN,
    ST_REDIRECT,
    ST_HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_cnt.sv
// fetch_timeout_cnt
// Counts how long the current instruction-memory request has been
// outstanding and flags the cycle in which it reaches the limit.
// Ports:
//   i_clk     clock, rising edge
//   i_rst     asynchronous active-low reset
//   i_clear   a new request starts next cycle (or none is pending): count -> 0
//   i_enable  request outstanding and memory not ready this cycle
//   o_expire  this waiting cycle is the LIMIT-th one in a row
module fetch_timeout_cnt #(
  parameter int LIMIT = fetch_ctrl_pkg::TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);
  import fetch_ctrl_pkg::*;

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= 8'd0;
    end else if (i_clear) begin
      r_cnt <= 8'd0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Expiry is flagged while the count would step onto LIMIT, so the
  // controller can move to HALT on that same edge.
  assign o_expire = i_enable && (r_cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Sequences the fetch stage: boot delay, instruction-memory handshakes,
// load-use stalls, branch redirects, halting and request timeout.
// Ports:
//   i_clk, i_rst            clock (rising edge), async active-low reset
//   o_imem_req/i_imem_ready instruction-memory handshake
//   i_branch_taken/_target  EX-stage redirect request and address
//   i_load_use, i_halt_req  hazard stall request, decode saw ecall/ebreak
//   o_pc_write, o_pc_src    fetch-stage PC load enable / branch select
//   o_pc_branch             registered redirect target
//   o_ifid_write, o_ifid_flush, o_idex_flush  pipeline register controls
//   o_halted, o_fetch_err   sticky status (cleared only by reset)
module fetch_ctrl #(
  parameter int XLEN        = fetch_ctrl_pkg::XLEN,
  parameter int BOOT_CYCLES = fetch_ctrl_pkg::BOOT_CYCLES,
  parameter int TIMEOUT     = fetch_ctrl_pkg::TIMEOUT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_req,
  input  logic            i_imem_ready,
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_branch_target,
  input  logic            i_load_use,
  input  logic            i_halt_req,
  output logic            o_pc_write,
  output logic            o_pc_src,
  output logic [XLEN-1:0] o_pc_branch,
  output logic            o_ifid_write,
  output logic            o_ifid_flush,
  output logic            o_idex_flush,
  output logic            o_halted,
  output logic            o_fetch_err
);
  import fetch_ctrl_pkg::*;

  fetch_state_t    r_state;
  fetch_state_t    w_next_state;
  logic [3:0]      r_boot_cnt;
  logic [XLEN-1:0] r_pc_branch;
  logic            r_halt_pend;
  logic            r_fetch_err;

  logic w_req;
  logic w_load_branch;
  logic w_set_pend;
  logic w_clr_pend;
  logic w_set_err;
  logic w_tmo_expire;

  // A request is outstanding in every state that waits on memory.
  assign w_req = (r_state == ST_FETCH) || (r_state == ST_WAIT_MEM) ||
                 (r_state == ST_DRAIN);

  fetch_timeout_cnt #(.LIMIT(TIMEOUT)) u_timeout (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (!w_req || i_imem_ready),
    .i_enable (w_req && !i_imem_ready),
    .o_expire (w_tmo_expire)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= ST_BOOT;
      r_boot_cnt  <= 4'(BOOT_CYCLES - 1);
      r_pc_branch <= '0;
      r_halt_pend <= 1'b0;
      r_fetch_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_BOOT && r_boot_cnt != 4'd0) begin
        r_boot_cnt <= r_boot_cnt - 4'd1;
      end
      if (w_load_branch) begin
        r_pc_branch <= i_branch_target;
      end
      if (w_clr_pend) begin
        r_halt_pend <= 1'b0;
      end else if (w_set_pend) begin
        r_halt_pend <= 1'b1;
      end
      if (w_set_err) begin
        r_fetch_err <= 1'b1;
      end
    end
  end

  // Next state and per-cycle controls. Within FETCH/WAIT_MEM the priority
  // is timeout > branch > halt (new or pending) > load-use > normal fetch.
  // A taken branch drops a pending halt, since the halting instruction is
  // younger than the branch and is being flushed.
  always_comb begin
    w_next_state  = r_state;
    o_pc_write    = 1'b0;
    o_pc_src      = 1'b0;
    o_ifid_write  = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_flush  = 1'b0;
    w_load_branch = 1'b0;
    w_set_pend    = 1'b0;
    w_clr_pend    = 1'b0;
    w_set_err     = 1'b0;
    case (r_state)
      ST_BOOT: begin
        if (r_boot_cnt == 4'd0) w_next_state = ST_FETCH;
      end
      ST_FETCH, ST_WAIT_MEM: begin
        if (w_tmo_expire) begin
          w_next_state = ST_HALT;
          w_set_err    = 1'b1;
        end else if (i_branch_taken) begin
          o_ifid_flush  = 1'b1;
          o_idex_flush  = 1'b1;
          w_load_branch = 1'b1;
          w_clr_pend    = 1'b1;
          w_next_state  = i_imem_ready ? ST_REDIRECT : ST_DRAIN;
        end else if (i_halt_req || r_halt_pend) begin
          w_set_pend   = !i_imem_ready;
          w_next_state = i_imem_ready ? ST_HALT : ST_WAIT_MEM;
        end else if (i_load_use) begin
          o_idex_flush = 1'b1;
        end else if (i_imem_ready) begin
          o_pc_write   = 1'b1;
          o_ifid_write = 1'b1;
          w_next_state = ST_FETCH;
        end else begin
          w_next_state = ST_WAIT_MEM;
        end
      end
      ST_DRAIN: begin
        if (w_tmo_expire) begin
          w_next_state = ST_HALT;
          w_set_err    = 1'b1;
        end else if (i_imem_ready) begin
          w_next_state = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        o_pc_src     = 1'b1;
        o_pc_write   = 1'b1;
        o_ifid_flush = 1'b1;
        w_next_state = ST_FETCH;
      end
      ST_HALT: begin
        w_next_state = ST_HALT;
      end
      default: begin
        w_next_state = ST_BOOT;
      end
    endcase
  end

  assign o_imem_req  = w_req;
  assign o_pc_branch = r_pc_branch;
  assign o_halted    = (r_state == ST_HALT);
  assign o_fetch_err = r_fetch_err;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter XLEN, default 32, address width of PC and branch target.
REQ-002 Parameter BOOT_CYCLES, default 2, idle cycles after reset release before first fetch (legal range 1..15).
REQ-003 Parameter TIMEOUT, default 16, max cycles one imem request may stay outstanding (legal range 2..255).
REQ-004 Ports, name direction width meaning:
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 imem_req  out  1  instruction-memory request, held until imem_ready.
REQ-008 imem_ready  in  1  instruction returned for current request; may be high in the same cycle as imem_req.
REQ-009 branch_taken  in  1  EX-stage taken branch/jump.
REQ-010 branch_target  in  XLEN  redirect address, valid with branch_taken.
REQ-011 load_use  in  1  hazard unit stall request.
REQ-012 halt_req  in  1  decode saw ecall/ebreak.
REQ-013 PCWrite, PCSrc  out  1 each  fetch_stage PC load enable and branch-select.
REQ-014 pc_branch  out  XLEN  registered target fed to fetch_stage.
REQ-015 ifid_write, ifid_flush, idex_flush  out  1 each  pipeline register controls.
REQ-016 halted, fetch_err  out  1 each  sticky status.

Function
REQ-017 States: BOOT, FETCH, WAIT_MEM, DRAIN, REDIRECT, HALT.
REQ-018 BOOT: all controls 0; down-counter from BOOT_CYCLES-1; at 0 -> FETCH.
REQ-019 FETCH/WAIT_MEM: imem_req=1; imem_ready=1 and no hazard -> PCWrite=1, ifid_write=1, PCSrc=0, stay/return FETCH; imem_ready=0 -> WAIT_MEM.
REQ-020 load_use=1 in FETCH/WAIT_MEM (no branch): PCWrite=0, ifid_write=0, idex_flush=1 same cycle; imem_req stays 1; state unchanged.
REQ-021 branch_taken=1 in FETCH/WAIT_MEM: branch_target registered into pc_branch; ifid_flush=1, idex_flush=1, PCWrite=0 same cycle; next state REDIRECT if imem_ready=1, else DRAIN.
REQ-022 DRAIN: imem_req=1, returned instruction discarded (ifid_write=0); on imem_ready -> REDIRECT.
REQ-023 REDIRECT: exactly one cycle, imem_req=0, PCSrc=1, PCWrite=1, ifid_flush=1; -> FETCH.
REQ-024 Priority in one cycle: branch_taken > halt_req > load_use > normal fetch.
REQ-025 halt_req (no branch) in FETCH/WAIT_MEM: PCWrite=0, ifid_write=0; -> HALT once imem_ready seen (immediately if high), else DRAIN-like wait in WAIT_MEM with halt pending flag.
REQ-026 HALT: all controls 0, halted=1; exit only by reset.
REQ-027 branch_taken, load_use, halt_req ignored in BOOT, REDIRECT, HALT.
REQ-028 Wait counter (8 bit) clears on each request issue, increments each cycle imem_req=1 and imem_ready=0; reaching TIMEOUT -> HALT with fetch_err=1 and halted=1.
REQ-029 All outputs except the ifid/idex flushes and PCWrite/ifid_write hazard gating are registered-state decodes; flushes are combinational from inputs, zero extra latency.

Reset
REQ-030 rst=0 asynchronously forces BOOT, boot counter=BOOT_CYCLES-1, wait counter=0, pc_branch=0, halted=0, fetch_err=0, halt pending=0, all control outputs 0.
REQ-031 Reset mid-request abandons it; no output toggles until BOOT completes after rst rises.

Structure
REQ-032 Package fetch_ctrl_pkg holds state enum fetch_state_t and default constants XLEN, BOOT_CYCLES, TIMEOUT.
REQ-033 One sub-module fetch_timeout_cnt (clear, enable, expire output) instantiated once.

Verification
REQ-034 Reset release, imem_ready tied 1 -> PCWrite first high on cycle BOOT_CYCLES (2) after rst rises, then every cycle; pc increments 0,4,8.
REQ-035 load_use high 2 cycles at pc=8 -> PCWrite=0, idex_flush=1 both cycles; pc holds 8, resumes 12.
REQ-036 branch_taken with target 20, imem_ready=1 -> flushes same cycle; next cycle PCSrc=1, PCWrite=1; pc=20 following edge.
REQ-037 branch_taken target 20 while imem_ready low 3 cycles -> DRAIN 3 cycles, ifid_write=0, then REDIRECT, pc=20.
REQ-038 branch_taken and load_use and halt_req together -> branch behaviour only, halted stays 0.
REQ-039 imem_ready held 0 for 16 cycles -> fetch_err=1, halted=1; rst low then high -> both clear, BOOT restarts.
